// File: rtl/phy_rx_pkg.sv
// Shared phy_rx/phy_tx definitions: alignment byte, sync depth, lane count and receiver states.
package phy_rx_pkg;

    localparam logic [7:0] COMMA      = 8'hBC;
    localparam int         SYNC_COUNT = 4;
    localparam int         NUM_LANES  = 4;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

endpackage

// File: rtl/phy_rx_if.sv
// Receiver-side bundle: serial line in, four lane bytes with strobes, link status and debug taps.
interface phy_rx_if;
    import phy_rx_pkg::*;

    // valid_N is a one-cycle strobe with no back-pressure: outN is new in exactly that
    // cycle and holds until the next strobe on the same lane.
    logic       data_out;
    logic [7:0] out0;
    logic [7:0] out1;
    logic [7:0] out2;
    logic [7:0] out3;
    logic       valid_0;
    logic       valid_1;
    logic       valid_2;
    logic       valid_3;
    logic       active;
    state_e     dbg_state;
    logic [7:0] dbg_sr;

    modport master (
        input  data_out,
        output out0, out1, out2, out3,
        output valid_0, valid_1, valid_2, valid_3,
        output active, dbg_state, dbg_sr
    );

    modport slave (
        output data_out,
        input  out0, out1, out2, out3,
        input  valid_0, valid_1, valid_2, valid_3,
        input  active, dbg_state, dbg_sr
    );

endinterface

// File: rtl/phy_rx_deser.sv
// Serial-to-window deserializer: shift register, bit counter and alignment-byte compare.
module phy_rx_deser #(
    parameter logic [7:0] COMMA = phy_rx_pkg::COMMA
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    input  logic       hold_cnt,
    output logic [7:0] window,
    output logic       is_comma,
    output logic       boundary,
    output logic [7:0] sr
);
    logic [7:0] sr_q, sr_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;

    // While hunting the counter is parked at 0 so the first byte after a match ends at count 7.
    always_comb begin
        window    = {sr_q[6:0], data_in};
        is_comma  = (window == COMMA);
        boundary  = (bit_cnt_q == 3'd7);
        sr_d      = window;
        bit_cnt_d = hold_cnt ? 3'd0 : bit_cnt_q + 3'd1;
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            sr_q      <= '0;
            bit_cnt_q <= '0;
        end else begin
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign sr = sr_q;

endmodule

// File: rtl/phy_rx.sv
// Four-lane serial receiver: comma hunt, sync verify, then lane demux of valid byte slots.
// Define PHY_RX_REGOUT_EN to add one register stage on outN, valid_N and active.
module phy_rx #(
    parameter logic [7:0] COMMA      = phy_rx_pkg::COMMA,
    parameter int         SYNC_COUNT = phy_rx_pkg::SYNC_COUNT
) (
    input logic      clk_32f,
    input logic      reset,
    phy_rx_if.master bus
);
    import phy_rx_pkg::*;

    localparam int CW = $clog2(SYNC_COUNT + 1);
    localparam int LW = $clog2(NUM_LANES);

    state_e                 state_q, state_d;
    logic [CW-1:0]          comma_cnt_q, comma_cnt_d, cnt_inc;
    logic [LW-1:0]          lane_q, lane_d;
    logic [7:0]             out_q [NUM_LANES];
    logic [7:0]             out_d [NUM_LANES];
    logic [NUM_LANES-1:0]   valid_q, valid_d;
    logic                   active_q, active_d;
    logic [7:0]             window;
    logic                   is_comma;
    logic                   boundary;
    logic [7:0]             sr;

    phy_rx_deser #(.COMMA(COMMA)) u_deser (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .data_in  (bus.data_out),
        .hold_cnt (state_q == ST_HUNT),
        .window   (window),
        .is_comma (is_comma),
        .boundary (boundary),
        .sr       (sr)
    );

    assign cnt_inc = comma_cnt_q + CW'(1);

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) state_q <= ST_HUNT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HUNT:   if (is_comma) state_d = ST_VERIFY;
            ST_VERIFY: if (boundary) begin
                if (!is_comma)                      state_d = ST_HUNT;
                else if (cnt_inc == CW'(SYNC_COUNT)) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: state_d = ST_ACTIVE;
            default:   state_d = ST_HUNT;
        endcase
    end

    // The hunt match is itself lane 0's comma, so the pointer resumes at lane 1.
    always_comb begin
        comma_cnt_d = comma_cnt_q;
        lane_d      = lane_q;
        out_d       = out_q;
        valid_d     = '0;
        active_d    = active_q;
        case (state_q)
            ST_HUNT: if (is_comma) begin
                comma_cnt_d = CW'(1);
                lane_d      = LW'(1);
            end
            ST_VERIFY: if (boundary) begin
                lane_d = lane_q + LW'(1);
                if (is_comma) begin
                    comma_cnt_d = cnt_inc;
                    if (cnt_inc == CW'(SYNC_COUNT)) active_d = 1'b1;
                end else begin
                    comma_cnt_d = '0;
                end
            end
            ST_ACTIVE: if (boundary) begin
                lane_d = lane_q + LW'(1);
                if (!is_comma) begin
                    out_d[lane_q]   = window;
                    valid_d[lane_q] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            comma_cnt_q <= '0;
            lane_q      <= '0;
            out_q       <= '{default: '0};
            valid_q     <= '0;
            active_q    <= 1'b0;
        end else begin
            comma_cnt_q <= comma_cnt_d;
            lane_q      <= lane_d;
            out_q       <= out_d;
            valid_q     <= valid_d;
            active_q    <= active_d;
        end
    end

`ifdef PHY_RX_REGOUT_EN
    logic [7:0]           out_p_q [NUM_LANES];
    logic [7:0]           out_p_d [NUM_LANES];
    logic [NUM_LANES-1:0] valid_p_q, valid_p_d;
    logic                 active_p_q, active_p_d;

    always_comb begin
        out_p_d    = out_q;
        valid_p_d  = valid_q;
        active_p_d = active_q;
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            out_p_q    <= '{default: '0};
            valid_p_q  <= '0;
            active_p_q <= 1'b0;
        end else begin
            out_p_q    <= out_p_d;
            valid_p_q  <= valid_p_d;
            active_p_q <= active_p_d;
        end
    end

    assign bus.out0    = out_p_q[0];
    assign bus.out1    = out_p_q[1];
    assign bus.out2    = out_p_q[2];
    assign bus.out3    = out_p_q[3];
    assign bus.valid_0 = valid_p_q[0];
    assign bus.valid_1 = valid_p_q[1];
    assign bus.valid_2 = valid_p_q[2];
    assign bus.valid_3 = valid_p_q[3];
    assign bus.active  = active_p_q;
`else
    assign bus.out0    = out_q[0];
    assign bus.out1    = out_q[1];
    assign bus.out2    = out_q[2];
    assign bus.out3    = out_q[3];
    assign bus.valid_0 = valid_q[0];
    assign bus.valid_1 = valid_q[1];
    assign bus.valid_2 = valid_q[2];
    assign bus.valid_3 = valid_q[3];
    assign bus.active  = active_q;
`endif

    assign bus.dbg_state = state_q;
    assign bus.dbg_sr    = sr;

endmodule
